// File: rtl/alsu_keypad_entry_pkg.sv
// Shared types and helpers for the ALSU keypad front-end: entry states,
// special key codes, scan result and debouncer encodings.
package alsu_kp_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    READY    = 2'd3
  } entry_state_e;

  localparam logic [3:0] KEY_EXEC = 4'hE;
  localparam logic [3:0] KEY_CLR  = 4'hF;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } scan_res_e;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } deb_state_e;

  function automatic logic [2:0] count_lows(input logic [3:0] lows);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) n = n + {2'b00, lows[i]};
    return n;
  endfunction

  // Lowest asserted row wins; only meaningful when exactly one is set.
  function automatic logic [1:0] first_low(input logic [3:0] lows);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) if (lows[3-i]) idx = 2'(3 - i);
    return idx;
  endfunction

endpackage

// File: rtl/alsu_keypad_entry_if.sv
// Keypad pins plus the command bundle presented to the ALSU.
interface alsu_kp_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] A;
  logic [2:0] B;
  logic [2:0] opcode;
  logic       cmd_valid;
  logic [1:0] entry_state;

  modport master (
    input  row,
    output col, key_valid, key_code, A, B, opcode, cmd_valid, entry_state
  );

  modport slave (
    output row,
    input  col, key_valid, key_code, A, B, opcode, cmd_valid, entry_state
  );
endinterface

// File: rtl/alsu_keypad_entry_keypad_scan.sv
// 4x4 keypad scanner: row synchronizer, column drive, per-scan result and
// press/release debouncer producing one key_valid pulse per press.
module keypad_scan
  import alsu_kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_key_valid,
  output logic [3:0] o_key_code
);
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]       r_row_s1, r_row_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [2:0]       r_low_acc;
  logic [3:0]       r_acc_code;
  deb_state_e       r_deb, w_deb_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]       r_last, w_last_nx;
  logic             r_kv, w_kv_nx;
  logic [3:0]       r_code, w_code_nx;

  logic             w_sample, w_scan_end;
  logic [2:0]       w_col_cnt, w_sum, w_tot;
  logic [3:0]       w_code;
  scan_res_e        w_res;

  assign w_sample   = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_scan_end = w_sample && (r_col == 2'd3);
  assign w_col_cnt  = count_lows(~r_row_s2);
  assign w_sum      = r_low_acc + w_col_cnt;
  // Total low count saturates at 2: anything above one is MULTI anyway.
  assign w_tot      = (w_sum > 3'd2) ? 3'd2 : w_sum;
  assign w_code     = (w_col_cnt != 3'd0) ? {first_low(~r_row_s2), r_col} : r_acc_code;
  assign w_res      = (w_tot == 3'd0) ? NONE : ((w_tot == 3'd1) ? KEY : MULTI);

  assign o_col       = ~(4'b0001 << r_col);
  assign o_key_valid = r_kv;
  assign o_key_code  = r_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1   <= '1;
      r_row_s2   <= '1;
      r_div      <= '0;
      r_col      <= '0;
      r_low_acc  <= '0;
      r_acc_code <= '0;
    end else begin
      r_row_s1 <= i_row;
      r_row_s2 <= r_row_s1;
      if (w_sample) begin
        r_div <= '0;
        r_col <= r_col + 2'd1;
        if (r_col == 2'd3) begin
          r_low_acc  <= '0;
          r_acc_code <= '0;
        end else begin
          r_low_acc  <= w_tot;
          r_acc_code <= w_code;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    w_deb_nx  = r_deb;
    w_cnt_nx  = r_cnt;
    w_last_nx = r_last;
    w_kv_nx   = 1'b0;
    w_code_nx = r_code;
    if (w_scan_end) begin
      case (r_deb)
        RELEASED: begin
          if (w_res == KEY) begin
            w_cnt_nx  = (r_cnt != '0 && w_code == r_last) ? r_cnt + CNT_W'(1) : CNT_W'(1);
            w_last_nx = w_code;
            if (w_cnt_nx == CNT_W'(DEBOUNCE_SCANS)) begin
              w_kv_nx   = 1'b1;
              w_code_nx = w_code;
              w_deb_nx  = PRESSED;
              w_cnt_nx  = '0;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        PRESSED: begin
          if (w_res == NONE) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
            if (w_cnt_nx == CNT_W'(DEBOUNCE_SCANS)) begin
              w_deb_nx = RELEASED;
              w_cnt_nx = '0;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        default: w_deb_nx = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb  <= RELEASED;
      r_cnt  <= '0;
      r_last <= '0;
      r_kv   <= 1'b0;
      r_code <= '0;
    end else begin
      r_deb  <= w_deb_nx;
      r_cnt  <= w_cnt_nx;
      r_last <= w_last_nx;
      r_kv   <= w_kv_nx;
      r_code <= w_code_nx;
    end
  end

endmodule

// File: rtl/alsu_keypad_entry.sv
// ALSU keypad front-end: keypad scanner plus the A/B/opcode entry state
// machine that issues a held command with a one-cycle cmd_valid strobe.
module alsu_keypad_entry
  import alsu_kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic      clk,
  input  logic      rst,
  alsu_kp_if.master bus
);
  logic [3:0]   w_col;
  logic         w_kv;
  logic [3:0]   w_key_code;
  entry_state_e r_state, w_state_nx;
  logic [2:0]   r_A, r_B, r_op, w_A_nx, w_B_nx, w_op_nx;
  logic         r_cmd, w_cmd_nx;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .i_row      (bus.row),
    .o_col      (w_col),
    .o_key_valid(w_kv),
    .o_key_code (w_key_code)
  );

  always_comb begin
    w_state_nx = r_state;
    w_A_nx     = r_A;
    w_B_nx     = r_B;
    w_op_nx    = r_op;
    w_cmd_nx   = 1'b0;
    if (w_kv) begin
      if (w_key_code == KEY_CLR) begin
        w_state_nx = ENTER_A;
      end else begin
        case (r_state)
          ENTER_A:  if (!w_key_code[3]) begin w_A_nx  = w_key_code[2:0]; w_state_nx = ENTER_B;  end
          ENTER_B:  if (!w_key_code[3]) begin w_B_nx  = w_key_code[2:0]; w_state_nx = ENTER_OP; end
          ENTER_OP: if (!w_key_code[3]) begin w_op_nx = w_key_code[2:0]; w_state_nx = READY;    end
          READY:    if (w_key_code == KEY_EXEC) begin w_cmd_nx = 1'b1; w_state_nx = ENTER_A; end
          default:  w_state_nx = ENTER_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_A     <= '0;
      r_B     <= '0;
      r_op    <= '0;
      r_cmd   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_A     <= w_A_nx;
      r_B     <= w_B_nx;
      r_op    <= w_op_nx;
      r_cmd   <= w_cmd_nx;
    end
  end

  assign bus.col         = w_col;
  assign bus.key_valid   = w_kv;
  assign bus.key_code    = w_key_code;
  assign bus.A           = r_A;
  assign bus.B           = r_B;
  assign bus.opcode      = r_op;
  assign bus.cmd_valid   = r_cmd;
  assign bus.entry_state = r_state;

endmodule

// File: tb/tb_alsu_keypad_entry.sv
// Bench for alsu_keypad_entry: keypad pressed-set model drives rows; directed
// table steps, a reset sequence and random steps are checked against a model.
module tb_alsu_keypad_entry;
  localparam int SD = 4;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_kp_if bus ();

  alsu_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Physical keypad: key 4*r+c pulls row r low while column c is driven low.
  logic [15:0] keys = '0;
  always_comb begin
    bus.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !bus.col[c]) bus.row[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          nscans;
    int          kv;
    logic [3:0]  code;
    int          cmd;
    logic [1:0]  st;
    logic [2:0]  a, b, op;
  } step_t;

  int         hist[$];
  bit         m_pressed;
  logic [3:0] m_code;
  int         m_st;
  logic [2:0] mA, mB, mOp;
  bit         cmd_due;
  int         obs_kv, obs_cmd;
  logic [3:0] obs_code;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_pressed = 0; m_code = '0; m_st = 0;
    mA = '0; mB = '0; mOp = '0; cmd_due = 0;
  endtask

  // -1 = no key, -2 = several keys, otherwise the single key's code.
  function automatic int scan_result(input logic [15:0] k);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return idx;
  endfunction

  // State flips when the last DB results since the previous flip all agree:
  // the same single key while released, no key while pressed.
  function automatic bit deb_step(input int r);
    bit was = m_pressed;
    int want = was ? -1 : r;
    hist.push_back(r);
    if (!was && r < 0) return 0;
    if (hist.size() < DB) return 0;
    for (int i = hist.size() - DB; i < hist.size(); i++) if (hist[i] != want) return 0;
    m_pressed = !was;
    hist.delete();
    return !was;
  endfunction

  task automatic entry_step(input int code);
    if (code == 15) m_st = 0;
    else if (m_st == 0 && code < 8) begin mA = 3'(code); m_st = 1; end
    else if (m_st == 1 && code < 8) begin mB = 3'(code); m_st = 2; end
    else if (m_st == 2 && code < 8) begin mOp = 3'(code); m_st = 3; end
    else if (m_st == 3 && code == 14) begin cmd_due = 1; m_st = 0; end
  endtask

  // One full scan (16 cycles), checked every cycle 1ns after the clock edge.
  task automatic run_scan(input logic [15:0] k);
    int   res;
    bit   kv_exp;
    logic [3:0] ecol;
    keys = k;
    res = scan_result(k);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      kv_exp = 0;
      if (j == 16) begin
        kv_exp = deb_step(res);
        if (kv_exp) m_code = 4'(res);
      end
      ecol = ~(4'b0001 << ((j / 4) % 4));
      chk("col", bus.col, ecol);
      chk("key_valid", bus.key_valid, kv_exp);
      chk("key_code", bus.key_code, m_code);
      chk("cmd_valid", bus.cmd_valid, (j == 1) && cmd_due);
      if (j == 1) begin
        chk("entry_state", bus.entry_state, m_st);
        chk("A", bus.A, mA);
        chk("B", bus.B, mB);
        chk("opcode", bus.opcode, mOp);
        cmd_due = 0;
      end
      obs_kv  += int'(bus.key_valid);
      obs_cmd += int'(bus.cmd_valid);
      if (bus.key_valid) obs_code = bus.key_code;
      if (j == 16 && kv_exp) entry_step(res);
    end
  endtask

  task automatic apply_step(input step_t s, input int idx);
    obs_kv = 0; obs_cmd = 0; obs_code = '0;
    for (int n = 0; n < s.nscans; n++) run_scan(s.keys);
    chk($sformatf("step%0d_kv_count", idx), obs_kv, s.kv);
    if (s.kv != 0) chk($sformatf("step%0d_code", idx), obs_code, s.code);
    chk($sformatf("step%0d_cmd_count", idx), obs_cmd, s.cmd);
    chk($sformatf("step%0d_state", idx), bus.entry_state, s.st);
    chk($sformatf("step%0d_A", idx), bus.A, s.a);
    chk($sformatf("step%0d_B", idx), bus.B, s.b);
    chk($sformatf("step%0d_op", idx), bus.opcode, s.op);
  endtask

  function automatic step_t press(input int k, input int n, input int kv, input int cmd,
                                  input int st, input int a, input int b, input int op);
    step_t s;
    s.keys = 16'(1) << k; s.nscans = n; s.kv = kv; s.code = 4'(k); s.cmd = cmd;
    s.st = 2'(st); s.a = 3'(a); s.b = 3'(b); s.op = 3'(op);
    return s;
  endfunction

  function automatic step_t rel(input int st, input int a, input int b, input int op);
    step_t s;
    s.keys = '0; s.nscans = 2; s.kv = 0; s.code = '0; s.cmd = 0;
    s.st = 2'(st); s.a = 3'(a); s.b = 3'(b); s.op = 3'(op);
    return s;
  endfunction

  function automatic int pick_key();
    int x = $urandom_range(0, 9);
    if (x < 6) return $urandom_range(0, 7);
    if (x == 6) return 14;
    if (x == 7) return 15;
    return $urandom_range(0, 15);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t tbl[$];
    step_t s;
    logic [15:0] rk;
    int k1, k2;

    s = rel(0, 0, 0, 0); s.nscans = 10; tbl.push_back(s);
    tbl.push_back(press(5, 3, 1, 0, 1, 5, 0, 0));  tbl.push_back(rel(1, 5, 0, 0));
    tbl.push_back(press(15, 3, 1, 0, 0, 5, 0, 0)); tbl.push_back(rel(0, 5, 0, 0));
    tbl.push_back(press(3, 3, 1, 0, 1, 3, 0, 0));  tbl.push_back(rel(1, 3, 0, 0));
    tbl.push_back(press(6, 3, 1, 0, 2, 3, 6, 0));  tbl.push_back(rel(2, 3, 6, 0));
    tbl.push_back(press(2, 3, 1, 0, 3, 3, 6, 2));  tbl.push_back(rel(3, 3, 6, 2));
    tbl.push_back(press(14, 3, 1, 1, 0, 3, 6, 2)); tbl.push_back(rel(0, 3, 6, 2));
    tbl.push_back(press(5, 3, 1, 0, 1, 5, 6, 2));  tbl.push_back(rel(1, 5, 6, 2));
    tbl.push_back(press(9, 3, 1, 0, 1, 5, 6, 2));  tbl.push_back(rel(1, 5, 6, 2));
    tbl.push_back(press(15, 3, 1, 0, 0, 5, 6, 2)); tbl.push_back(rel(0, 5, 6, 2));
    s = rel(0, 5, 6, 2); s.keys = 16'h0042; s.nscans = 4; tbl.push_back(s);
    tbl.push_back(press(6, 3, 1, 0, 1, 6, 6, 2));  tbl.push_back(rel(1, 6, 6, 2));
    tbl.push_back(press(14, 3, 1, 0, 1, 6, 6, 2)); tbl.push_back(rel(1, 6, 6, 2));
    tbl.push_back(press(7, 3, 1, 0, 2, 6, 7, 2));  tbl.push_back(rel(2, 6, 7, 2));
    tbl.push_back(press(0, 3, 1, 0, 3, 6, 7, 0));  tbl.push_back(rel(3, 6, 7, 0));
    tbl.push_back(press(4, 1, 0, 0, 3, 6, 7, 0));

    model_reset();
    keys = '0;
    repeat (3) @(negedge clk);
    chk("rst_col", bus.col, 4'b1110);
    chk("rst_key_valid", bus.key_valid, 1'b0);
    chk("rst_key_code", bus.key_code, 4'h0);
    chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
    chk("rst_state", bus.entry_state, 2'd0);
    chk("rst_A", bus.A, 3'd0);
    rst = 1'b0;

    foreach (tbl[i]) apply_step(tbl[i], i);

    // Reset while READY with key 4 still held: immediate clear, then the
    // held key must be re-accepted after two full scans.
    rst = 1'b1;
    #1;
    chk("arst_col", bus.col, 4'b1110);
    chk("arst_key_code", bus.key_code, 4'h0);
    chk("arst_state", bus.entry_state, 2'd0);
    chk("arst_A", bus.A, 3'd0);
    chk("arst_B", bus.B, 3'd0);
    chk("arst_op", bus.opcode, 3'd0);
    chk("arst_cmd", bus.cmd_valid, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_kv = 0;
    run_scan(16'h0010);
    chk("arst_no_kv_after_1_scan", obs_kv, 0);
    run_scan(16'h0010);
    chk("arst_kv_after_2_scans", obs_kv, 1);
    chk("arst_kv_code", obs_code, 4'h4);
    run_scan(16'h0010);
    chk("arst_A_after_key", bus.A, 3'd4);
    chk("arst_state_after_key", bus.entry_state, 2'd1);
    run_scan('0);
    run_scan('0);

    for (int i = 0; i < 80; i++) begin
      k1 = $urandom_range(0, 9);
      if (k1 < 3) rk = '0;
      else if (k1 < 9) rk = 16'(1) << pick_key();
      else begin
        k1 = $urandom_range(0, 15);
        k2 = (k1 + 1 + $urandom_range(0, 14)) % 16;
        rk = (16'(1) << k1) | (16'(1) << k2);
      end
      k2 = $urandom_range(1, 4);
      for (int n = 0; n < k2; n++) run_scan(rk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
